mult_div_unit: RTL and testbench

Iterative 32-bit multiply/divide unit for the multi-cycle MIPS datapath. It executes MULT, MULTU, DIV and DIVU over 34 clock cycles and holds the 64-bit result in internal HI/LO registers. It also services MTHI/MTLO writes. The HI/LO outputs are the source for MFHI/MFLO and feed the datapath's 32-bit ALUOut-style holding registers. The main control FSM stalls on `busy` and is told the result is ready by `done`.

---
 rtl/mult_div_unit.sv | 159 +++++++++++++++
 tb/tb_mult_div_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative 32-bit multiply/divide unit for the multi-cycle MIPS datapath.
// Executes MULT, MULTU, DIV and DIVU in 34 cycles (1 start edge, 32 iterations,
// 1 sign-fix edge) and holds the 64-bit result in HI/LO. Also services MTHI/MTLO.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted here
// CALC  | one shift-add / restoring-divide iteration per cycle, counter 31..0
// FIX   | sign correction, write hi/lo, pulse done
//
// Ports:
//   clk    in   1  clock, rising edge
//   rst    in   1  asynchronous reset, active low
//   start  in   1  begin operation selected by op on a, b (ignored while busy)
//   op     in   2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a      in  32  multiplicand / dividend
//   b      in  32  multiplier / divisor
//   hi_we  in   1  MTHI: write wdata into HI (idle only)
//   lo_we  in   1  MTLO: write wdata into LO (idle only)
//   wdata  in  32  MTHI/MTLO data
//   hi     out 32  HI register (high product / remainder)
//   lo     out 32  LO register (low product / quotient)
//   busy   out  1  operation in progress
//   done   out  1  one-cycle pulse, new hi/lo valid
module mult_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] opnd;     // multiplicand |a| for multiply, divisor |b| for divide
  logic [31:0] a_orig;   // raw dividend, returned in hi on divide by zero
  logic [63:0] acc;      // {upper, multiplier} or {remainder, dividend/quotient}

  // Start-edge operand preparation
  logic        st_sa, st_sb;
  logic [31:0] st_ma, st_mb;

  always_comb begin
    st_sa = ~op[0] & a[31];
    st_sb = ~op[0] & b[31];
    st_ma = st_sa ? (~a + 32'd1) : a;
    st_mb = st_sb ? (~b + 32'd1) : b;
  end

  // One iteration
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] acc_next;

  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    div_shift = {acc[63:32], acc[31]};
    div_ge    = div_shift >= {1'b0, opnd};
    // When div_ge holds the difference is below the divisor, so 32 bits suffice
    div_sub   = div_shift[31:0] - opnd;
    if (is_div)
      acc_next = {(div_ge ? div_sub : div_shift[31:0]), acc[30:0], div_ge};
    else
      acc_next = {mul_sum, acc[31:1]};
  end

  // Sign correction and final result
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? (~acc + 64'd1) : acc;
    quo_fix  = (sign_a ^ sign_b) ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem_fix  = sign_a ? (~acc[63:32] + 32'd1) : acc[63:32];
    if (!is_div) begin
      fix_hi = prod_fix[63:32];
      fix_lo = prod_fix[31:0];
    end else if (opnd == 32'd0) begin
      fix_hi = a_orig;
      fix_lo = 32'hFFFF_FFFF;
    end else begin
      fix_hi = rem_fix;
      fix_lo = quo_fix;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      opnd   <= 32'd0;
      a_orig <= 32'd0;
      acc    <= 64'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            is_div <= op[1];
            sign_a <= st_sa;
            sign_b <= st_sb;
            a_orig <= a;
            opnd   <= op[1] ? st_mb : st_ma;
            acc    <= {32'd0, (op[1] ? st_ma : st_mb)};
            cnt    <= 5'd31;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          if (cnt == 5'd0)
            state <= FIX;
          else
            cnt <= cnt - 5'd1;
        end
        FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        hi_we, lo_we;
  logic [31:0] hi, lo;
  logic        busy, done;

  int errors   = 0;
  int checks   = 0;
  int done_cnt = 0;
  logic [63:0] sb_q[$];

  mult_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model built on native 64-bit arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    if (o[1] && y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (o[0]) begin
      sx = longint'({32'd0, x});
      sy = longint'({32'd0, y});
    end else begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end
    if (!o[1]) begin
      p = sx * sy;
      return p;
    end
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  // Scoreboard consumer
  always @(posedge clk) begin
    logic [63:0] exp;
    #1;
    if (done === 1'b1) begin
      done_cnt++;
      check("busy_done_excl", {63'd0, busy}, 64'd0);
      if (sb_q.size() == 0)
        check("unexpected_done", 64'd1, 64'd0);
      else begin
        exp = sb_q.pop_front();
        check("result_hi_lo", {hi, lo}, exp);
      end
    end
  end

  task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [63:0] exp, input string tag);
    int n, bc;
    op = o; a = x; b = y; start = 1'b1;
    sb_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    bc = busy ? 1 : 0;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (busy) bc++;
    end
    check({tag, "_latency"}, 64'(n), 64'd33);
    check({tag, "_busy_cycles"}, 64'(bc), 64'd33);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    logic [31:0] hold_hi;
    logic [1:0]  ro;
    logic [31:0] rx, ry;

    rst = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    #12;
    check("reset_state", {hi, lo}, 64'd0);
    check("reset_flags", {62'd0, busy, done}, 64'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    run(2'd0, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, "mult_neg");
    @(negedge clk);
    run(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, "multu_max");
    // Launched in the done cycle of the previous operation
    run(2'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_b2b");
    @(negedge clk);
    run(2'd3, 32'd100, 32'd0, {32'h0000_0064, 32'hFFFF_FFFF}, "divu_zero");
    @(negedge clk);
    run(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, "div_ovf");
    @(negedge clk);
    run(2'd2, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, "div_zero_neg");

    // start and MTHI while busy must be ignored
    @(negedge clk);
    d0 = done_cnt;
    hold_hi = hi;
    op = 2'd1; a = 32'd7; b = 32'd6; start = 1'b1;
    sb_q.push_back({32'd0, 32'd42});
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1; op = 2'd3; a = 32'd99; b = 32'd0; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    check("hi_we_ignored_busy", {32'd0, hi}, {32'd0, hold_hi});
    repeat (60) @(posedge clk);
    #1;
    check("single_done", 64'(done_cnt - d0), 64'd1);
    check("idle_after_ignore", {63'd0, busy}, 64'd0);

    // MTHI / MTLO
    @(negedge clk);
    d0 = done_cnt;
    hi_we = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    check("mthi", {32'd0, hi}, {32'd0, 32'h1234_5678});
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    check("mtlo", {hi, lo}, {32'h1234_5678, 32'h9ABC_DEF0});
    @(negedge clk); lo_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mthi_mtlo_no_done", 64'(done_cnt - d0), 64'd0);

    // Reset mid-operation
    @(negedge clk);
    op = 2'd3; a = 32'd1000; b = 32'd3; start = 1'b1;
    sb_q.push_back({32'd1, 32'd333});
    @(posedge clk); #1; start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_hi_lo", {hi, lo}, 64'd0);
    check("abort_flags", {62'd0, busy, done}, 64'd0);
    check("abort_pending", 64'(sb_q.size()), 64'd1);
    sb_q.delete();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    run(2'd3, 32'd1000, 32'd3, {32'd1, 32'd333}, "divu_after_rst");

    // Random operations against the model
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = (i == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
      if (i == 5) ry = 32'hFFFF_FFFF;
      run(ro, rx, ry, model(ro, rx, ry), "random");
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
